token_repeat_scheduler: RTL and testbench

- Shares one serial token-repeat datapath among N_CH requesting serial channels.
- A round-robin arbiter grants one channel at a time and latches that channel's repeat factor.
- The block then emits each incoming '1' token 'factor' times on a single serial output, draining pending tokens after the burst ends.
- Sits between the channel token sources and the shared serial sink; flags a sticky overflow when the pending backlog exceeds MAX_PEND.

---
 rtl/token_repeat_scheduler.sv | 149 ++++++++++++++
 tb/tb_token_repeat_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/token_repeat_scheduler.sv
// token_repeat_scheduler
// Round-robin shares one serial token-repeat datapath among N_CH channels.
// The granted channel's '1' tokens are each emitted eff_factor times on b.
// Tokens that are still owed when the burst ends are drained afterwards.
// A pending backlog above MAX_PEND sets a sticky overflow and halts the block.
module token_repeat_scheduler #(
   parameter int N_CH     = 4,
   parameter int FACTOR_W = 2,
   parameter int MAX_PEND = 200,
   parameter int CNT_W    = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_CH-1:0]           req,
   input  logic [N_CH-1:0]           a,
   input  logic [N_CH*FACTOR_W-1:0]  factor,
   output logic [N_CH-1:0]           grant,
   output logic                      b,
   output logic                      busy,
   output logic                      overflow,
   output logic [$clog2(N_CH)-1:0]   ovf_ch
);

   localparam int IDX_W = $clog2(N_CH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t              r_state, w_state_next;
   logic [N_CH-1:0]     r_grant, w_grant_next;
   logic [CNT_W-1:0]    r_pend, w_pend_next, w_run_pend;
   logic [IDX_W-1:0]    r_ptr, w_ptr_next;
   logic [IDX_W-1:0]    r_gidx, w_gidx_next;
   logic [IDX_W-1:0]    r_ovf_ch, w_ovf_ch_next;
   logic [IDX_W-1:0]    w_win;
   logic [FACTOR_W-1:0] r_eff, w_eff_next, w_win_factor;
   logic                r_ovf, w_ovf_next;
   logic                w_found, w_tok, w_b, w_busy;

   // Round-robin search: first requester after the pointer, wrapping mod N_CH
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         if (!w_found && req[(32'(r_ptr) + k) % N_CH]) begin
            w_found = 1'b1;
            w_win   = IDX_W'((32'(r_ptr) + k) % N_CH);
         end
      end
      w_win_factor = factor[w_win*FACTOR_W +: FACTOR_W];
   end

   // Next-state, pending arithmetic and serial output
   always_comb begin
      w_state_next  = r_state;
      w_grant_next  = r_grant;
      w_pend_next   = r_pend;
      w_ptr_next    = r_ptr;
      w_gidx_next   = r_gidx;
      w_eff_next    = r_eff;
      w_ovf_next    = r_ovf;
      w_ovf_ch_next = r_ovf_ch;
      w_b           = 1'b0;
      w_busy        = 1'b0;

      // a token only counts while the granted channel still holds its request
      w_tok = req[r_gidx] & a[r_gidx];
      if (w_tok)
         w_run_pend = r_pend + CNT_W'(r_eff) - CNT_W'(1);
      else if (r_pend != '0)
         w_run_pend = r_pend - CNT_W'(1);
      else
         w_run_pend = r_pend;

      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_grant_next = N_CH'(1) << w_win;
               w_ptr_next   = w_win;
               w_gidx_next  = w_win;
               w_eff_next   = (w_win_factor == '0) ? FACTOR_W'(1) : w_win_factor;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            w_busy = 1'b1;
            w_b    = w_tok | (r_pend != '0);
            // overflow is tested on the unsaturated sum before it is committed
            if (w_run_pend > CNT_W'(MAX_PEND)) begin
               w_ovf_next    = 1'b1;
               w_ovf_ch_next = r_gidx;
               w_grant_next  = '0;
               w_pend_next   = '0;
               w_state_next  = S_HALT;
            end else begin
               w_pend_next = w_run_pend;
               if (!req[r_gidx]) begin
                  w_grant_next = '0;
                  w_state_next = (w_run_pend != '0) ? S_DRAIN : S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            w_busy      = 1'b1;
            w_b         = 1'b1;
            w_pend_next = r_pend - CNT_W'(1);
            if (w_pend_next == '0)
               w_state_next = S_IDLE;
         end
         S_HALT: begin
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_pend   <= '0;
         r_ptr    <= IDX_W'(N_CH - 1);
         r_gidx   <= '0;
         r_eff    <= FACTOR_W'(1);
         r_ovf    <= 1'b0;
         r_ovf_ch <= '0;
      end else begin
         r_state  <= w_state_next;
         r_grant  <= w_grant_next;
         r_pend   <= w_pend_next;
         r_ptr    <= w_ptr_next;
         r_gidx   <= w_gidx_next;
         r_eff    <= w_eff_next;
         r_ovf    <= w_ovf_next;
         r_ovf_ch <= w_ovf_ch_next;
      end
   end

   assign grant    = r_grant;
   assign b        = w_b;
   assign busy     = w_busy;
   assign overflow = r_ovf;
   assign ovf_ch   = r_ovf_ch;

endmodule

// File: tb/tb_token_repeat_scheduler.sv
// Scoreboard bench for token_repeat_scheduler: the driver pushes the
// hand-computed response of each cycle, the monitor pops and compares it.
module tb_token_repeat_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] a;
   logic [7:0] factor;
   logic [3:0] grant;
   logic       b;
   logic       busy;
   logic       overflow;
   logic [1:0] ovf_ch;

   typedef struct {
      logic [3:0] grant;
      logic       b;
      logic       busy;
      logic       ovf;
      logic [1:0] ovf_ch;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // factor word: ch3=2, ch2=3, ch1=0, ch0=2
   localparam logic [7:0] FAC   = 8'b10_11_00_10;
   // same but ch0 changed to 3, applied mid-burst to show it is ignored
   localparam logic [7:0] FAC_X = 8'b10_11_00_11;

   token_repeat_scheduler #(
      .N_CH(4), .FACTOR_W(2), .MAX_PEND(200), .CNT_W(9)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .a(a), .factor(factor),
      .grant(grant), .b(b), .busy(busy), .overflow(overflow), .ovf_ch(ovf_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the edge and queue its expected response
   task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] av,
                       input logic [7:0] fc, input logic [3:0] eg, input logic eb,
                       input logic ebusy, input logic eo, input logic [1:0] ec,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst    = r;
      req    = rq;
      a      = av;
      factor = fc;
      e.grant = eg; e.b = eb; e.busy = ebusy; e.ovf = eo; e.ovf_ch = ec; e.name = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: compare the DUT against the queued expectation mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (grant !== e.grant) begin
               n_err++;
               $display("FAIL %s grant: got %b want %b (t=%0t)", e.name, grant, e.grant, $time);
            end
            if (b !== e.b) begin
               n_err++;
               $display("FAIL %s b: got %b want %b (t=%0t)", e.name, b, e.b, $time);
            end
            if (busy !== e.busy) begin
               n_err++;
               $display("FAIL %s busy: got %b want %b (t=%0t)", e.name, busy, e.busy, $time);
            end
            if (overflow !== e.ovf) begin
               n_err++;
               $display("FAIL %s overflow: got %b want %b (t=%0t)", e.name, overflow, e.ovf, $time);
            end
            if (ovf_ch !== e.ovf_ch) begin
               n_err++;
               $display("FAIL %s ovf_ch: got %0d want %0d (t=%0t)", e.name, ovf_ch, e.ovf_ch, $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pat_a, pat_b;
      logic [3:0] pat4;
      rst = 1'b0; req = '0; a = '0; factor = FAC;

      // reset state
      step(0, 4'b0000, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "reset");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "idle0");

      // round robin: 0001, 0010, 0100, 1000, then wraps to 0001
      for (int ch = 0; ch < 4; ch++) begin
         step(1, 4'b1111, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "rr_idle");
         repeat (2) step(1, 4'b1111, 4'b0000, FAC, 4'(1 << ch), 0, 1, 0, 2'd0, "rr_run");
         step(1, 4'b1111 & ~4'(1 << ch), 4'b0000, FAC, 4'(1 << ch), 0, 1, 0, 2'd0, "rr_end");
      end
      step(1, 4'b1111, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "rr_idle");
      step(1, 4'b1111, 4'b0000, FAC, 4'b0001, 0, 1, 0, 2'd0, "rr_wrap");
      step(1, 4'b1110, 4'b0000, FAC, 4'b0001, 0, 1, 0, 2'd0, "rr_wrap_end");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "rr_done");

      // ch2 factor 3, single token: b=111 then 0
      step(1, 4'b0100, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "f3_idle");
      step(1, 4'b0100, 4'b0100, FAC, 4'b0100, 1, 1, 0, 2'd0, "f3_tok");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0100, 1, 1, 0, 2'd0, "f3_end");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0000, 1, 1, 0, 2'd0, "f3_drain");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "f3_idle_after");

      // ch1 factor 0 acts as pass-through: b=1011, no drain
      pat4 = 4'b1011;
      step(1, 4'b0010, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "f0_idle");
      for (int i = 0; i < 4; i++)
         step(1, 4'b0010, {2'b00, pat4[3-i], 1'b0}, FAC, 4'b0010, pat4[3-i], 1, 0, 2'd0, "f0_run");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0010, 0, 1, 0, 2'd0, "f0_end");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "f0_idle_after");

      // ch0 factor 2, a0=10010011 -> b=11011011 then 11; mid-burst factor change ignored
      pat_a = 8'b10010011;
      pat_b = 8'b11011011;
      step(1, 4'b0001, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "f2_idle");
      for (int i = 0; i < 8; i++)
         step(1, 4'b0001, {3'b000, pat_a[7-i]}, FAC_X, 4'b0001, pat_b[7-i], 1, 0, 2'd0, "f2_run");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0001, 1, 1, 0, 2'd0, "f2_end");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0000, 1, 1, 0, 2'd0, "f2_drain");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "f2_idle_after");

      // ch3 factor 2, continuous tokens: overflow on the 201st
      step(1, 4'b1000, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "ov_idle");
      for (int i = 0; i < 200; i++)
         step(1, 4'b1000, 4'b1000, FAC, 4'b1000, 1, 1, 0, 2'd0, "ov_fill");
      step(1, 4'b1000, 4'b1000, FAC, 4'b1000, 1, 1, 0, 2'd0, "ov_trigger");
      repeat (3) step(1, 4'b1111, 4'b1111, FAC, 4'b0000, 0, 0, 1, 2'd3, "ov_halt");
      step(0, 4'b1111, 4'b1111, FAC, 4'b0000, 0, 0, 0, 2'd0, "ov_reset");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "ov_idle_after");

      // async reset mid-drain, then ch0 wins the first arbitration
      step(1, 4'b0100, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "ar_idle");
      step(1, 4'b0100, 4'b0100, FAC, 4'b0100, 1, 1, 0, 2'd0, "ar_tok");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0100, 1, 1, 0, 2'd0, "ar_end");
      step(0, 4'b0000, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "ar_reset");
      step(1, 4'b1111, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "ar_idle2");
      step(1, 4'b1111, 4'b0000, FAC, 4'b0001, 0, 1, 0, 2'd0, "ar_ch0_first");
      step(1, 4'b1110, 4'b0000, FAC, 4'b0001, 0, 1, 0, 2'd0, "ar_ch0_end");
      step(1, 4'b0000, 4'b0000, FAC, 4'b0000, 0, 0, 0, 2'd0, "ar_done");

      repeat (4) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
